// File: rtl/game_round_if.sv
// Round-controller bundle: frame/goal/start requests in, game status and ball control out.
// Purely combinational wiring; adds no latency.
// No backpressure: every request is sampled on the cycle it is presented.
interface game_round_if;
  logic       frame_tick;
  logic       start;
  logic       goal_left;
  logic       goal_right;
  logic [2:0] state;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] winner;
  logic       serve_dir;
  logic       ball_load;
  logic       ball_run;

  // Stimulus / game-logic side: drives the requests and observes the status.
  modport master (
    output frame_tick, start, goal_left, goal_right,
    input  state, p1_score, p2_score, winner, serve_dir, ball_load, ball_run
  );

  // Controller side.
  modport slave (
    input  frame_tick, start, goal_left, goal_right,
    output state, p1_score, p2_score, winner, serve_dir, ball_load, ball_run
  );
endinterface

// File: rtl/game_round_controller.sv
// Pong round controller: IDLE -> SERVE -> PLAY -> POINT/OVER, with scoring and serve direction.
// State and scores update one cycle after a frame_tick; ball_load and ball_run decode the state register directly.
// No backpressure; ROUND_AUTOSTART_EN adds an idle counter that starts a game after AUTOSTART_FRAMES idle ticks.
module game_round_controller #(
  parameter int WIN_SCORE        = 7,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 90,
  parameter int AUTOSTART_FRAMES = 600
) (
  input  logic         clk,
  input  logic         reset,
  game_round_if.slave  bus
);

  // Reject parameter values the 3-bit scores and 10-bit frame counters cannot hold.
  if (WIN_SCORE < 1 || WIN_SCORE > 7)
    $error("WIN_SCORE must be in 1..7");
  if (SERVE_FRAMES < 1 || SERVE_FRAMES > 1023)
    $error("SERVE_FRAMES must be in 1..1023");
  if (POINT_FRAMES < 1 || POINT_FRAMES > 1023)
    $error("POINT_FRAMES must be in 1..1023");
  if (AUTOSTART_FRAMES < 1 || AUTOSTART_FRAMES > 1023)
    $error("AUTOSTART_FRAMES must be in 1..1023");

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [2:0] WIN_Q      = 3'(WIN_SCORE);
  localparam logic [9:0] SERVE_LOAD = 10'(SERVE_FRAMES - 1);
  localparam logic [9:0] POINT_LOAD = 10'(POINT_FRAMES - 1);

  state_t     state_q, state_d;
  logic [2:0] p1_q, p1_d;
  logic [2:0] p2_q, p2_d;
  logic [1:0] winner_q, winner_d;
  logic       dir_q, dir_d;
  logic [9:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       idle_or_over;
  logic       go;

`ifdef ROUND_AUTOSTART_EN
  localparam logic [9:0] AUTO_LAST = 10'(AUTOSTART_FRAMES - 1);
  logic [9:0] idle_q, idle_d;
`endif

  assign idle_or_over = (state_q == S_IDLE) || (state_q == S_OVER);

  // A game begins on a tick in IDLE/OVER when start is held, was latched earlier, or the idle timer expires.
  always_comb begin
    go = idle_or_over && bus.frame_tick && (pend_q || bus.start);
`ifdef ROUND_AUTOSTART_EN
    if (idle_or_over && bus.frame_tick && (idle_q == AUTO_LAST)) go = 1'b1;
`endif
  end

  // Next-state, scoring and frame counting; everything except start latching waits for frame_tick.
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
`ifdef ROUND_AUTOSTART_EN
    idle_d   = idle_or_over ? idle_q : 10'd0;
    if (idle_or_over && bus.frame_tick) idle_d = idle_q + 10'd1;
`endif

    // A start request between ticks is remembered until the next tick.
    if (idle_or_over && bus.start) pend_d = 1'b1;

    if (bus.frame_tick) begin
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (go) begin
            pend_d   = 1'b0;
            p1_d     = 3'd0;
            p2_d     = 3'd0;
            winner_d = 2'd0;
            cnt_d    = SERVE_LOAD;
            state_d  = S_SERVE;
`ifdef ROUND_AUTOSTART_EN
            idle_d   = 10'd0;
`endif
          end
        end
        S_SERVE: begin
          if (cnt_q == 10'd0) state_d = S_PLAY;
          else                cnt_d   = cnt_q - 10'd1;
        end
        S_PLAY: begin
          // A double touch is ambiguous and scores nothing; the score guards keep counters from passing WIN_SCORE.
          if (bus.goal_right && !bus.goal_left && (p1_q < WIN_Q)) begin
            p1_d  = p1_q + 3'd1;
            dir_d = 1'b1;
            if (p1_d == WIN_Q) begin
              winner_d = 2'd1;
              state_d  = S_OVER;
            end else begin
              cnt_d   = POINT_LOAD;
              state_d = S_POINT;
            end
          end else if (bus.goal_left && !bus.goal_right && (p2_q < WIN_Q)) begin
            p2_d  = p2_q + 3'd1;
            dir_d = 1'b0;
            if (p2_d == WIN_Q) begin
              winner_d = 2'd2;
              state_d  = S_OVER;
            end else begin
              cnt_d   = POINT_LOAD;
              state_d = S_POINT;
            end
          end
        end
        S_POINT: begin
          if (cnt_q == 10'd0) begin
            cnt_d   = SERVE_LOAD;
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register with asynchronous clear to a fresh, idle game.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      p1_q     <= 3'd0;
      p2_q     <= 3'd0;
      winner_q <= 2'd0;
      dir_q    <= 1'b0;
      cnt_q    <= 10'd0;
      pend_q   <= 1'b0;
`ifdef ROUND_AUTOSTART_EN
      idle_q   <= 10'd0;
`endif
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
`ifdef ROUND_AUTOSTART_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign bus.state     = state_q;
  assign bus.p1_score  = p1_q;
  assign bus.p2_score  = p2_q;
  assign bus.winner    = winner_q;
  assign bus.serve_dir = dir_q;
  assign bus.ball_load = (state_q == S_IDLE) || (state_q == S_SERVE);
  assign bus.ball_run  = (state_q == S_PLAY);

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller with SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=2, AUTOSTART_FRAMES=4.
// Each step pushes the expected post-edge status into a scoreboard and pops it once the DUT has updated.
// No backpressure exists; stimulus is applied on the falling edge and sampled 1 ns after the rising edge.
module tb_game_round_controller;

  localparam int ST_IDLE  = 0;
  localparam int ST_SERVE = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_POINT = 3;
  localparam int ST_OVER  = 4;

  typedef struct {
    string tag;
    int    st;
    int    p1;
    int    p2;
    int    win;
    int    dir;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb_q[$];

  game_round_if bus();

  game_round_controller #(
    .WIN_SCORE(2),
    .SERVE_FRAMES(2),
    .POINT_FRAMES(3),
    .AUTOSTART_FRAMES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input int st, input int p1, input int p2,
                          input int win, input int dir);
    exp_t e;
    e.tag = tag; e.st = st; e.p1 = p1; e.p2 = p2; e.win = win; e.dir = dir;
    sb_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, ".state"},     int'(bus.state),     e.st);
    check_val({e.tag, ".p1"},        int'(bus.p1_score),  e.p1);
    check_val({e.tag, ".p2"},        int'(bus.p2_score),  e.p2);
    check_val({e.tag, ".winner"},    int'(bus.winner),    e.win);
    check_val({e.tag, ".serve_dir"}, int'(bus.serve_dir), e.dir);
    check_val({e.tag, ".ball_load"}, int'(bus.ball_load),
              (e.st == ST_IDLE || e.st == ST_SERVE) ? 1 : 0);
    check_val({e.tag, ".ball_run"},  int'(bus.ball_run), (e.st == ST_PLAY) ? 1 : 0);
  endtask

  // One clock of stimulus; inputs are held for exactly one cycle.
  task automatic step(input string tag, input logic st_i, input logic ft, input logic gl,
                      input logic gr, input int e_st, input int e_p1, input int e_p2,
                      input int e_win, input int e_dir);
    push_exp(tag, e_st, e_p1, e_p2, e_win, e_dir);
    @(negedge clk);
    bus.start      = st_i;
    bus.frame_tick = ft;
    bus.goal_left  = gl;
    bus.goal_right = gr;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.goal_left  = 1'b0;
    bus.goal_right = 1'b0;
    pop_compare();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.goal_left  = 1'b0;
    bus.goal_right = 1'b0;
    reset = 1'b0;
    #3;
    push_exp("reset", ST_IDLE, 0, 0, 0, 0);
    pop_compare();
    @(negedge clk);
    reset = 1'b1;

    // Start pulse between ticks, then serve countdown into play.
    step("start_no_tick", 1, 0, 0, 0, ST_IDLE,  0, 0, 0, 0);
    step("tick_to_serve", 0, 1, 0, 0, ST_SERVE, 0, 0, 0, 0);
    step("serve_1",       0, 1, 0, 0, ST_SERVE, 0, 0, 0, 0);
    step("serve_to_play", 0, 1, 0, 0, ST_PLAY,  0, 0, 0, 0);
    // Start ignored outside IDLE/OVER must not re-enter SERVE later.
    step("start_in_play", 1, 0, 0, 0, ST_PLAY,  0, 0, 0, 0);
    step("double_goal",   0, 1, 1, 1, ST_PLAY,  0, 0, 0, 0);
    step("p1_goal",       0, 1, 0, 1, ST_POINT, 1, 0, 0, 1);
    step("point_1",       0, 1, 0, 0, ST_POINT, 1, 0, 0, 1);
    step("point_2",       0, 1, 0, 0, ST_POINT, 1, 0, 0, 1);
    step("point_to_srv",  0, 1, 0, 0, ST_SERVE, 1, 0, 0, 1);
    step("goal_in_serve", 0, 1, 1, 0, ST_SERVE, 1, 0, 0, 1);
    step("serve2_play",   0, 1, 0, 0, ST_PLAY,  1, 0, 0, 1);
    step("goal_no_tick",  0, 0, 0, 1, ST_PLAY,  1, 0, 0, 1);
    step("p1_wins",       0, 1, 0, 1, ST_OVER,  2, 0, 1, 1);
    step("goal_in_over",  0, 1, 0, 1, ST_OVER,  2, 0, 1, 1);
    step("restart",       1, 1, 0, 0, ST_SERVE, 0, 0, 0, 1);
    step("rs_serve",      0, 1, 0, 0, ST_SERVE, 0, 0, 0, 1);
    step("rs_play",       0, 1, 0, 0, ST_PLAY,  0, 0, 0, 1);
    step("p2_goal",       0, 1, 1, 0, ST_POINT, 0, 1, 0, 0);
    step("p2_point_1",    0, 1, 0, 0, ST_POINT, 0, 1, 0, 0);
    step("p2_point_2",    0, 1, 0, 0, ST_POINT, 0, 1, 0, 0);
    step("p2_to_serve",   0, 1, 0, 0, ST_SERVE, 0, 1, 0, 0);
    step("p2_serve",      0, 1, 0, 0, ST_SERVE, 0, 1, 0, 0);
    step("p2_play",       0, 1, 0, 0, ST_PLAY,  0, 1, 0, 0);

    // Asynchronous reset mid-play, checked before any further clock edge.
    #1;
    reset = 1'b0;
    #1;
    push_exp("async_reset", ST_IDLE, 0, 0, 0, 0);
    pop_compare();
    @(negedge clk);
    reset = 1'b1;

    // Idle ticks with no start request.
    step("idle_1", 0, 1, 0, 0, ST_IDLE, 0, 0, 0, 0);
    step("idle_2", 0, 1, 0, 0, ST_IDLE, 0, 0, 0, 0);
    step("idle_3", 0, 1, 0, 0, ST_IDLE, 0, 0, 0, 0);
`ifdef ROUND_AUTOSTART_EN
    step("idle_4_auto", 0, 1, 0, 0, ST_SERVE, 0, 0, 0, 0);
`else
    step("idle_4_hold", 0, 1, 0, 0, ST_IDLE,  0, 0, 0, 0);
`endif

    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
